// File: rtl/mem_wb_if.sv
// mem_wb_if: M-stage inputs and W-stage outputs of the memory/writeback pipeline register.
interface mem_wb_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
) ();
    logic                      StallW;
    logic                      FlushW;
    logic                      ValidM;
    logic                      RegWriteM;
    logic [1:0]                ResultSrcM;
    logic [2:0]                LoadSizeM;
    logic [DATA_WIDTH-1:0]     ALUResultM;
    logic [DATA_WIDTH-1:0]     ReadDataM;
    logic [REG_ADDR_WIDTH-1:0] RdM;
    logic [DATA_WIDTH-1:0]     PC_PlusM;
    logic                      ValidW;
    logic                      RegWriteW;
    logic [REG_ADDR_WIDTH-1:0] RdW;
    logic [DATA_WIDTH-1:0]     ResultW;
    logic [CNT_WIDTH-1:0]      RetireCount;

    modport master (
        output StallW, FlushW, ValidM, RegWriteM, ResultSrcM, LoadSizeM,
               ALUResultM, ReadDataM, RdM, PC_PlusM,
        input  ValidW, RegWriteW, RdW, ResultW, RetireCount
    );

    modport slave (
        input  StallW, FlushW, ValidM, RegWriteM, ResultSrcM, LoadSizeM,
               ALUResultM, ReadDataM, RdM, PC_PlusM,
        output ValidW, RegWriteW, RdW, ResultW, RetireCount
    );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: M->W pipeline register with load alignment/extension, result select and retire counter.
module mem_wb_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
) (
    input logic     clk,
    input logic     rst_n,
    mem_wb_if.slave bus
);
    localparam int OFF_W = $clog2(DATA_WIDTH / 8);

    logic                      valid_w;
    logic                      regwrite_w;
    logic [REG_ADDR_WIDTH-1:0] rd_w;
    logic [1:0]                src_w;
    logic [DATA_WIDTH-1:0]     alu_w;
    logic [DATA_WIDTH-1:0]     load_w;
    logic [DATA_WIDTH-1:0]     pcp_w;
    logic [CNT_WIDTH-1:0]      cnt;
    logic [DATA_WIDTH-1:0]     sh;
    logic [DATA_WIDTH-1:0]     ld;
    logic [OFF_W-1:0]          off;

    // Misaligned offsets simply shift; vacated upper lanes fill with zero before extension.
    always_comb begin
        off = bus.ALUResultM[OFF_W-1:0];
        sh  = bus.ReadDataM >> {off, 3'b000};
        case (bus.LoadSizeM)
            3'b000:  ld = DATA_WIDTH'($signed(sh[7:0]));
            3'b001:  ld = DATA_WIDTH'($signed(sh[15:0]));
            3'b010:  ld = DATA_WIDTH'($signed(sh[31:0]));
            3'b100:  ld = DATA_WIDTH'(sh[7:0]);
            3'b101:  ld = DATA_WIDTH'(sh[15:0]);
            3'b110:  ld = DATA_WIDTH'(sh[31:0]);
            default: ld = bus.ReadDataM;
        endcase
    end

    // Flush only kills the incoming slot; the instruction leaving W still retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_w    <= 1'b0;
            regwrite_w <= 1'b0;
            rd_w       <= '0;
            src_w      <= 2'b00;
            alu_w      <= '0;
            load_w     <= '0;
            pcp_w      <= '0;
            cnt        <= '0;
        end else begin
            if (bus.FlushW) begin
                valid_w    <= 1'b0;
                regwrite_w <= 1'b0;
            end else if (!bus.StallW) begin
                valid_w    <= bus.ValidM;
                regwrite_w <= bus.RegWriteM;
                rd_w       <= bus.RdM;
                src_w      <= bus.ResultSrcM;
                alu_w      <= bus.ALUResultM;
                load_w     <= ld;
                pcp_w      <= bus.PC_PlusM;
            end
            if (valid_w && !bus.StallW)
                cnt <= cnt + CNT_WIDTH'(1);
        end
    end

    assign bus.ValidW      = valid_w;
    assign bus.RdW         = rd_w;
    assign bus.RegWriteW   = regwrite_w & valid_w & (|rd_w);
    assign bus.RetireCount = cnt;
    assign bus.ResultW     = src_w == 2'b00 ? alu_w :
                             src_w == 2'b01 ? load_w :
                             src_w == 2'b10 ? pcp_w : '0;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed checks of capture, load extension, stall/flush, x0, counter wrap and async reset.
module tb_mem_wb_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mem_wb_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(4)) bus ();
    mem_wb_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic [1:0] src, input logic [2:0] sz,
                         input logic [31:0] alu, input logic [31:0] rdata, input logic [4:0] rd,
                         input logic [31:0] pcp);
        bus.ValidM     = v;
        bus.RegWriteM  = rw;
        bus.ResultSrcM = src;
        bus.LoadSizeM  = sz;
        bus.ALUResultM = alu;
        bus.ReadDataM  = rdata;
        bus.RdM        = rd;
        bus.PC_PlusM   = pcp;
    endtask

    typedef struct {
        logic [2:0]  sz;
        logic [31:0] alu;
        logic [31:0] res;
    } ld_vec_t;

    ld_vec_t lv[8] = '{
        '{3'b000, 32'h1002, 32'hFFFFFFFF},
        '{3'b100, 32'h1002, 32'h000000FF},
        '{3'b001, 32'h1002, 32'hFFFF80FF},
        '{3'b011, 32'h1002, 32'h80FF7F01},
        '{3'b101, 32'h1002, 32'h000080FF},
        '{3'b010, 32'h1000, 32'h80FF7F01},
        '{3'b000, 32'h1001, 32'h0000007F},
        '{3'b001, 32'h1003, 32'h00000080}
    };

    initial begin
        bus.StallW = 1'b0;
        bus.FlushW = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 3'b000, '0, '0, '0, '0);
        #1;
        chk("rst_valid", 64'(bus.ValidW), 64'd0);
        chk("rst_regwrite", 64'(bus.RegWriteW), 64'd0);
        chk("rst_result", 64'(bus.ResultW), 64'd0);
        chk("rst_count", 64'(bus.RetireCount), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        drive(1'b1, 1'b1, 2'b00, 3'b000, 32'h1234, '0, 5'd5, '0);
        step();
        chk("cap_valid", 64'(bus.ValidW), 64'd1);
        chk("cap_rd", 64'(bus.RdW), 64'd5);
        chk("cap_regwrite", 64'(bus.RegWriteW), 64'd1);
        chk("cap_result", 64'(bus.ResultW), 64'h1234);
        chk("cap_count", 64'(bus.RetireCount), 64'd0);

        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 2'b01, lv[i].sz, lv[i].alu, 32'h80FF7F01, 5'd6, '0);
            step();
            chk($sformatf("load%0d", i), 64'(bus.ResultW), 64'(lv[i].res));
            chk($sformatf("load%0d_count", i), 64'(bus.RetireCount), 64'(i + 1));
        end

        drive(1'b1, 1'b1, 2'b10, 3'b000, 32'h77, '0, 5'd0, 32'h104);
        step();
        chk("x0_regwrite", 64'(bus.RegWriteW), 64'd0);
        chk("x0_result", 64'(bus.ResultW), 64'h104);
        chk("x0_count", 64'(bus.RetireCount), 64'd9);

        drive(1'b1, 1'b1, 2'b11, 3'b000, 32'h77, '0, 5'd7, 32'h108);
        step();
        chk("src11_result", 64'(bus.ResultW), 64'd0);
        chk("src11_regwrite", 64'(bus.RegWriteW), 64'd1);

        drive(1'b1, 1'b0, 2'b00, 3'b000, 32'hABCD, '0, 5'd7, '0);
        step();
        chk("norw_regwrite", 64'(bus.RegWriteW), 64'd0);
        chk("norw_result", 64'(bus.ResultW), 64'hABCD);
        chk("norw_count", 64'(bus.RetireCount), 64'd11);

        drive(1'b1, 1'b1, 2'b00, 3'b000, 32'h5555, '0, 5'd9, '0);
        bus.StallW = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_result", 64'(bus.ResultW), 64'hABCD);
            chk("stall_rd", 64'(bus.RdW), 64'd7);
            chk("stall_valid", 64'(bus.ValidW), 64'd1);
            chk("stall_count", 64'(bus.RetireCount), 64'd11);
        end

        bus.FlushW = 1'b1;
        step();
        chk("sf_valid", 64'(bus.ValidW), 64'd0);
        chk("sf_regwrite", 64'(bus.RegWriteW), 64'd0);
        chk("sf_count", 64'(bus.RetireCount), 64'd11);

        bus.StallW = 1'b0;
        bus.FlushW = 1'b0;
        step();
        chk("resume_valid", 64'(bus.ValidW), 64'd1);
        chk("resume_result", 64'(bus.ResultW), 64'h5555);
        chk("resume_regwrite", 64'(bus.RegWriteW), 64'd1);
        chk("resume_count", 64'(bus.RetireCount), 64'd11);

        bus.FlushW = 1'b1;
        step();
        chk("flush_valid", 64'(bus.ValidW), 64'd0);
        chk("flush_count", 64'(bus.RetireCount), 64'd12);
        bus.FlushW = 1'b0;
        step();
        chk("unflush_valid", 64'(bus.ValidW), 64'd1);
        chk("unflush_count", 64'(bus.RetireCount), 64'd12);

        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(bus.ValidW), 64'd0);
        chk("arst_regwrite", 64'(bus.RegWriteW), 64'd0);
        chk("arst_result", 64'(bus.ResultW), 64'd0);
        chk("arst_count", 64'(bus.RetireCount), 64'd0);
        #2;
        rst_n = 1'b1;
        step();
        chk("post_rst_valid", 64'(bus.ValidW), 64'd1);
        chk("post_rst_result", 64'(bus.ResultW), 64'h5555);
        chk("post_rst_count", 64'(bus.RetireCount), 64'd0);

        for (int i = 1; i <= 17; i++) begin
            step();
            chk($sformatf("wrap%0d", i), 64'(bus.RetireCount), 64'(i % 16));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
